muxn_pipe: RTL and testbench
============================

Name: muxn_pipe

Overview:
Parametrised N-input datapath select mux with a registered output stage, valid/ready handshake, flush and illegal-select detection. It generalises the fixed 3-input, 32-bit combinational select used for operand and forwarding selection in the RV32I datapath. Where a pipelined select is needed, it is placed between the hazard/forwarding selectors and the ALU or writeback paths. It adds one cycle of latency, and backpressure stalls it cleanly.

Parameters:
WIDTH, 32, data width of each input and of the output
NUM_IN, 3, number of selectable inputs (2..16)
SEL_W, $clog2(NUM_IN) (minimum 1), select field width (derived; do not override)
ERR_CNT_W, 8, width of the saturating illegal-select counter

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_mux_in  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
i_mux_sel  input  SEL_W  binary select, sampled with i_valid
i_valid  input  1  upstream offers in/sel this cycle
o_ready  output  1  block can accept this cycle
o_mux_out  output  WIDTH  registered selected data
o_valid  output  1  o_mux_out holds a valid result
i_ready  input  1  downstream accepts o_mux_out this cycle
i_flush  input  1  drops the pending result and any input offered this cycle
o_sel_err  output  1  registered flag: the current o_mux_out came from an illegal select
o_err_sticky  output  1  sticky flag: an illegal select has been accepted since the last clear
i_err_clr  input  1  clears o_err_sticky and o_err_cnt
o_err_cnt  output  ERR_CNT_W  saturating count of accepted illegal selects

Behaviour:
- Reset (i_rst high, asynchronous): o_valid=0, o_mux_out=0, o_sel_err=0, o_err_sticky=0, o_err_cnt=0. Reset takes effect mid-transfer with no drain.
- o_ready = !o_valid || i_ready. It is combinational and does not depend on i_valid.
- Accept = i_valid && o_ready && !i_flush.
- On accept, the next edge loads o_mux_out = selected input, o_sel_err = illegal, and sets o_valid=1. Latency is exactly 1 cycle.
- Select rule: sel < NUM_IN picks input sel. sel >= NUM_IN is illegal; the output is all zeros. Only possible when NUM_IN is not a power of 2.
- Output held while o_valid && !i_ready: o_mux_out, o_sel_err and o_valid hold stable. Input changes are ignored.
- Output consumed with no new accept (o_valid && i_ready && !accept): the next edge clears o_valid. o_mux_out keeps its last value.
- Consume and accept in the same cycle: the new data loads with no bubble. Full throughput is 1 per cycle.
- i_flush: the next edge clears o_valid and o_sel_err. Flush beats accept and hold. Error counters are unaffected by a flushed input.
- Error accounting happens on an accepted illegal select only:
  - o_err_sticky is set.
  - o_err_cnt increments and saturates at all-ones; it does not wrap.
- i_err_clr in the same cycle as an accepted illegal select: the set wins. o_err_sticky=1 and o_err_cnt=1.
- i_err_clr alone: o_err_sticky=0 and o_err_cnt=0 at the next edge.
- No combinational path from i_mux_in or i_mux_sel to any output.
- When NUM_IN is a power of 2, the illegal logic is constant 0 and is optimised away.

Decomposition:
- Shared package datapath_pkg holds:
  - XLEN=32
  - function sel_width(n), returning max(1, $clog2(n))
  - enum fwd_sel_e {FWD_NONE=0, FWD_MEM=1, FWD_WB=2}, reused by forwarding instances with NUM_IN=3
- One combinational sub-module, muxn_comb (WIDTH, NUM_IN): packed inputs plus select give data out and an illegal flag.
- muxn_pipe wraps muxn_comb with the handshake register and the error counters.

Test Plan:
- NUM_IN=3, WIDTH=32, inputs A=0x11111111, B=0x22222222, C=0x33333333; sel 0,1,2 on consecutive cycles with i_ready=1 -> o_mux_out A,B,C one cycle after each; o_valid stays 1; o_sel_err=0.
- Same setup, sel=3 accepted -> next cycle o_mux_out=0, o_sel_err=1, o_err_sticky=1, o_err_cnt=1.
- Backpressure: load B, hold i_ready=0 for 4 cycles while inputs change -> o_mux_out stays 0x22222222; o_ready=0; then i_ready=1 with sel=2 offered -> C appears the next cycle with no bubble.
- i_flush asserted with o_valid=1 and i_valid=1 (sel=3) -> next cycle o_valid=0; o_err_cnt unchanged.
- ERR_CNT_W=2: 5 accepted illegal selects -> o_err_cnt 1,2,3,3,3. Then i_err_clr together with a sixth illegal select -> o_err_cnt=1, o_err_sticky=1.
- Assert i_rst asynchronously mid-stream between clock edges -> all outputs zero immediately, before the next edge; the first accept after release gives correct data after 1 cycle.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: XLEN, select-width helper and the forwarding
// select encoding reused by 3-input forwarding muxes.
package datapath_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  // Select field width for an n-input mux; never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 32'sd1) begin
      return 32'sd1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/muxn_comb.sv
// Combinational N-input select: picks one WIDTH-bit slice of the packed input
// bus and flags select codes with no corresponding input.
module muxn_comb
  import datapath_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] mux_in,
  input  logic [SEL_W-1:0]        mux_sel,
  output logic [WIDTH-1:0]        mux_out,
  output logic                    illegal
);

  logic [WIDTH-1:0] words_s [NUM_IN];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
    assign words_s[k] = mux_in[k*WIDTH +: WIDTH];
  end

  // Select the addressed word; codes past the last input yield zero and raise
  // illegal. For power-of-two NUM_IN the compare is constant true.
  always_comb begin
    mux_out = '0;
    illegal = 1'b0;
    if (int'(mux_sel) < NUM_IN) begin
      mux_out = words_s[mux_sel];
      illegal = 1'b0;
    end else begin
      mux_out = '0;
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// Registered N-input select with valid/ready handshake, flush, and
// illegal-select accounting (sticky flag plus saturating counter).
module muxn_pipe
  import datapath_pkg::*;
#(
  parameter int WIDTH     = XLEN,
  parameter int NUM_IN    = 3,
  parameter int SEL_W     = sel_width(NUM_IN),
  parameter int ERR_CNT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_IN*WIDTH-1:0] i_mux_in,
  input  logic [SEL_W-1:0]        i_mux_sel,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [WIDTH-1:0]        o_mux_out,
  output logic                    o_valid,
  input  logic                    i_ready,
  input  logic                    i_flush,
  output logic                    o_sel_err,
  output logic                    o_err_sticky,
  input  logic                    i_err_clr,
  output logic [ERR_CNT_W-1:0]    o_err_cnt
);

  logic [WIDTH-1:0]     sel_data_s;
  logic                 illegal_s;
  logic                 accept_s;
  logic [ERR_CNT_W-1:0] cnt_inc_s;

  logic [WIDTH-1:0]     out_r;
  logic                 valid_r;
  logic                 sel_err_r;
  logic                 sticky_r;
  logic [ERR_CNT_W-1:0] cnt_r;

  muxn_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_comb (
    .mux_in  (i_mux_in),
    .mux_sel (i_mux_sel),
    .mux_out (sel_data_s),
    .illegal (illegal_s)
  );

  // The stage can take a new word whenever it is empty or being drained.
  assign o_ready  = !valid_r || i_ready;
  assign accept_s = i_valid && o_ready && !i_flush;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  always_comb begin
    if (&cnt_r) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + ERR_CNT_W'(1);
    end
  end

  // Output stage: flush beats accept, accept beats hold, consume clears valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_r     <= '0;
      valid_r   <= 1'b0;
      sel_err_r <= 1'b0;
    end else if (i_flush) begin
      valid_r   <= 1'b0;
      sel_err_r <= 1'b0;
    end else if (accept_s) begin
      out_r     <= sel_data_s;
      valid_r   <= 1'b1;
      sel_err_r <= illegal_s;
    end else if (i_ready) begin
      valid_r   <= 1'b0;
    end else begin
      valid_r   <= valid_r;
    end
  end

  // Error accounting; an accepted illegal select overrides a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sticky_r <= 1'b0;
      cnt_r    <= '0;
    end else if (accept_s && illegal_s) begin
      sticky_r <= 1'b1;
      cnt_r    <= i_err_clr ? ERR_CNT_W'(1) : cnt_inc_s;
    end else if (i_err_clr) begin
      sticky_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      sticky_r <= sticky_r;
      cnt_r    <= cnt_r;
    end
  end

  assign o_mux_out    = out_r;
  assign o_valid      = valid_r;
  assign o_sel_err    = sel_err_r;
  assign o_err_sticky = sticky_r;
  assign o_err_cnt    = cnt_r;

endmodule

// File: tb/tb_muxn_pipe.sv
// Scoreboard bench for muxn_pipe: a directed prologue then random traffic,
// with two instances (8-bit and 2-bit error counters) sharing stimulus.
module tb_muxn_pipe;
  import datapath_pkg::*;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = sel_width(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] mux_in;
  logic [SW-1:0]  sel;
  logic           valid, ready_dn, flush, clr;

  logic           rdy, ov, serr, sticky;
  logic [W-1:0]   out;
  logic [7:0]     cnt;
  logic           rdy2, ov2, serr2, sticky2;
  logic [W-1:0]   out2;
  logic [1:0]     cnt2;

  muxn_pipe #(.WIDTH(W), .NUM_IN(N), .ERR_CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_mux_in(mux_in), .i_mux_sel(sel),
    .i_valid(valid), .o_ready(rdy), .o_mux_out(out), .o_valid(ov),
    .i_ready(ready_dn), .i_flush(flush), .o_sel_err(serr),
    .o_err_sticky(sticky), .i_err_clr(clr), .o_err_cnt(cnt)
  );

  muxn_pipe #(.WIDTH(W), .NUM_IN(N), .ERR_CNT_W(2)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_mux_in(mux_in), .i_mux_sel(sel),
    .i_valid(valid), .o_ready(rdy2), .o_mux_out(out2), .o_valid(ov2),
    .i_ready(ready_dn), .i_flush(flush), .o_sel_err(serr2),
    .o_err_sticky(sticky2), .i_err_clr(clr), .o_err_cnt(cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         e;
  } item_t;

  item_t        q[$];
  logic [W-1:0] words [N];
  int           pushed_now = 0;
  bit           in_rst = 1'b1;
  bit           exp_rdy_now = 1'b1;
  logic [7:0]   cur8 = 8'd0, nxt8 = 8'd0;
  logic [1:0]   cur2 = 2'd0, nxt2 = 2'd0;
  logic         cur_st = 1'b0, nxt_st = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a select code names an input word, anything else is an error.
  function automatic item_t ref_sel(input int s);
    item_t it;
    if (s < N) begin
      it.d = words[s];
      it.e = 1'b0;
    end else begin
      it.d = '0;
      it.e = 1'b1;
    end
    return it;
  endfunction

  // One clock of stimulus; predicts acceptance and next error-counter state.
  task automatic step(input bit v, input int s, input bit r, input bit f, input bit c);
    bit acc;
    item_t it;
    @(posedge clk);
    #1;
    cur8 = nxt8; cur2 = nxt2; cur_st = nxt_st;
    valid = v; sel = SW'(s); ready_dn = r; flush = f; clr = c;
    for (int k = 0; k < N; k++) mux_in[k*W +: W] = words[k];
    exp_rdy_now = (q.size() == 0) || r;
    acc = v && exp_rdy_now && !f;
    pushed_now = 0;
    if (acc) begin
      it = ref_sel(s);
      q.push_back(it);
      pushed_now = 1;
      if (it.e) begin
        nxt_st = 1'b1;
        nxt8 = c ? 8'd1 : ((cur8 == 8'hff) ? cur8 : cur8 + 8'd1);
        nxt2 = c ? 2'd1 : ((cur2 == 2'd3) ? cur2 : cur2 + 2'd1);
      end else if (c) begin
        nxt_st = 1'b0; nxt8 = 8'd0; nxt2 = 2'd0;
      end
    end else if (c) begin
      nxt_st = 1'b0; nxt8 = 8'd0; nxt2 = 2'd0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, ov, 1'b0);
    check({tag, "_out"}, out, '0);
    check({tag, "_serr"}, serr, 1'b0);
    check({tag, "_sticky"}, sticky, 1'b0);
    check({tag, "_cnt"}, cnt, 8'd0);
    check({tag, "_valid_s"}, ov2, 1'b0);
    check({tag, "_cnt_s"}, cnt2, 2'd0);
  endtask

  // Monitor: compare the presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!in_rst) begin
      bit has;
      has = (q.size() - pushed_now) > 0;
      check("o_valid", ov, has);
      check("o_valid_s", ov2, has);
      check("o_ready", rdy, exp_rdy_now);
      check("o_ready_s", rdy2, exp_rdy_now);
      check("err_cnt", cnt, cur8);
      check("err_cnt_s", cnt2, cur2);
      check("err_sticky", sticky, cur_st);
      check("err_sticky_s", sticky2, cur_st);
      if (has) begin
        check("mux_out", out, q[0].d);
        check("mux_out_s", out2, q[0].d);
        check("sel_err", serr, q[0].e);
        if (flush || ready_dn) void'(q.pop_front());
      end
    end
  end

  task automatic clear_model();
    q.delete();
    pushed_now = 0;
    exp_rdy_now = 1'b1;
    cur8 = 8'd0; nxt8 = 8'd0; cur2 = 2'd0; nxt2 = 2'd0;
    cur_st = 1'b0; nxt_st = 1'b0;
  endtask

  task automatic rand_words();
    for (int k = 0; k < N; k++) words[k] = $urandom;
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      rand_words();
      step($urandom_range(99, 0) < 75, $urandom_range(3, 0),
           $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 8,
           $urandom_range(99, 0) < 5);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; sel = '0; ready_dn = 1'b0; flush = 1'b0; clr = 1'b0;
    mux_in = '0;
    #2;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    in_rst = 1'b0;

    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    step(1'b1, 0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0, 1'b0);
    // Backpressure: hold B while inputs churn, then C follows with no bubble.
    step(1'b1, 1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rand_words();
      step(1'b1, $urandom_range(3, 0), 1'b0, 1'b0, 1'b0);
    end
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    step(1'b1, 2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);

    rand_steps(1500);

    // Asynchronous reset between edges while traffic is in flight.
    rand_words();
    step(1'b1, 3, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    in_rst = 1'b1;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    in_rst = 1'b0;
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    step(1'b1, 1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);

    rand_steps(400);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_rst = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
